// File: rtl/dcmem_pkg.sv
// rtl/dcmem_pkg.sv - shared constants for the dcmem arbiter slice
package dcmem_pkg;

  // Default dcmem geometry
  localparam int DEF_MEM_ADDR_WIDTH = 5;
  localparam int DEF_MEM_DATA_WIDTH = 16;

  // Arbiter FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN_A = 2'd1;
  localparam logic [1:0] ST_OWN_B = 2'd2;

  // Requester identifiers (also the bit index in req/gnt vectors)
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin picker
module rr_pick2
  import dcmem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // A sole requester always wins; on a tie the port that did not win last time goes
  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || last == PORT_B)) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/dcmem_arbiter.sv
// rtl/dcmem_arbiter.sv - two-port round-robin arbiter with bounded lock for dcmem
module dcmem_arbiter
  import dcmem_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
  parameter int MEM_DATA_WIDTH = DEF_MEM_DATA_WIDTH,
  parameter int MAX_LOCK       = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      a_req,
  input  logic                      a_lock,
  input  logic                      a_we,
  input  logic [MEM_ADDR_WIDTH-1:0] a_addr,
  input  logic [MEM_DATA_WIDTH-1:0] a_wdata,
  output logic                      a_gnt,
  output logic                      a_rvalid,
  output logic [MEM_DATA_WIDTH-1:0] a_rdata,
  input  logic                      b_req,
  input  logic                      b_lock,
  input  logic                      b_we,
  input  logic [MEM_ADDR_WIDTH-1:0] b_addr,
  input  logic [MEM_DATA_WIDTH-1:0] b_wdata,
  output logic                      b_gnt,
  output logic                      b_rvalid,
  output logic [MEM_DATA_WIDTH-1:0] b_rdata,
  output logic                      mem_wen,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [MEM_DATA_WIDTH-1:0] mem_wdata,
  input  logic [MEM_DATA_WIDTH-1:0] mem_rdata
);

  // Counter must hold MAX_LOCK+1 without wrapping so the release compare is exact
  localparam int CW = $clog2(MAX_LOCK + 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOCK);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [1:0]    state;
  logic          last;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_plus;
  logic [CW-1:0] cnt_next;
  logic [1:0]    pick_gnt;

  rr_pick2 u_pick (
    .req  ({b_req, a_req}),
    .last (last),
    .gnt  (pick_gnt)
  );

  assign cnt_plus = cnt + CNT_ONE;
  assign cnt_next = (cnt_plus > CNT_MAX) ? CNT_MAX : cnt_plus;

  // Grant decode: picker in IDLE, owner-only while locked, nothing during reset
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE:  {b_gnt, a_gnt} = pick_gnt;
        ST_OWN_A: a_gnt = a_req;
        ST_OWN_B: b_gnt = b_req;
        default:  ;
      endcase
    end
  end

  // Memory port mux; A's address/data are parked on the bus when idle
  always_comb begin
    mem_wen   = 1'b0;
    mem_addr  = a_addr;
    mem_wdata = a_wdata;
    if (a_gnt) begin
      mem_wen = a_we;
    end else if (b_gnt) begin
      mem_wen   = b_we;
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
    end
  end

  // Ownership FSM with bounded lock; forced release keeps last=owner so the other wins next
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      last  <= PORT_B;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (a_gnt) begin
            last <= PORT_A;
            if (a_lock) begin
              state <= ST_OWN_A;
              cnt   <= CNT_ONE;
            end
          end else if (b_gnt) begin
            last <= PORT_B;
            if (b_lock) begin
              state <= ST_OWN_B;
              cnt   <= CNT_ONE;
            end
          end
        end
        ST_OWN_A: begin
          if (!a_req) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt_next;
            if (!a_lock || (b_req && cnt_plus >= CNT_MAX)) state <= ST_IDLE;
          end
        end
        ST_OWN_B: begin
          if (!b_req) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt_next;
            if (!b_lock || (a_req && cnt_plus >= CNT_MAX)) state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Read return: capture dcmem data at the end of a granted read, valid for one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rvalid <= 1'b0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= a_gnt && !a_we;
      b_rvalid <= b_gnt && !b_we;
      if (a_gnt && !a_we) a_rdata <= mem_rdata;
      if (b_gnt && !b_we) b_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dcmem_arbiter.sv
// tb/tb_dcmem_arbiter.sv - directed vector bench for dcmem_arbiter
module tb_dcmem_arbiter;
  import dcmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_lock, a_we, b_req, b_lock, b_we;
  logic [4:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid, mem_wen;
  logic [15:0] a_rdata, b_rdata, mem_wdata, mem_rdata;
  logic [4:0]  mem_addr;

  logic [15:0] ram [0:31];

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  dcmem_arbiter #(.MEM_ADDR_WIDTH(5), .MEM_DATA_WIDTH(16), .MAX_LOCK(4)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_lock(a_lock), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_lock(b_lock), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // dcmem model: combinational read, write at posedge, preload while reset is held over an edge
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) ram[i] <= (i == 3) ? 16'h1234 : 16'h1000 + 16'(i);
    end else if (mem_wen) begin
      ram[mem_addr] <= mem_wdata;
    end
  end

  typedef struct {
    logic        ar, aw;
    logic [4:0]  aa;
    logic [15:0] ad;
    logic        br, bw;
    logic [4:0]  ba;
    logic [15:0] bd;
    logic        eag, ebg, ewen;
    logic [4:0]  eaddr;
    logic        eav;
    logic [15:0] ead;
    logic        ebv;
    logic [15:0] ebd;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(logic ar, logic aw, logic [4:0] aa, logic [15:0] ad,
                              logic br, logic bw, logic [4:0] ba, logic [15:0] bd,
                              logic eag, logic ebg, logic ewen, logic [4:0] eaddr,
                              logic eav, logic [15:0] ead, logic ebv, logic [15:0] ebd);
    vec_t v;
    v.ar = ar; v.aw = aw; v.aa = aa; v.ad = ad;
    v.br = br; v.bw = bw; v.ba = ba; v.bd = bd;
    v.eag = eag; v.ebg = ebg; v.ewen = ewen; v.eaddr = eaddr;
    v.eav = eav; v.ead = ead; v.ebv = ebv; v.ebd = ebd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ar, input logic al, input logic aw, input logic [4:0] aa,
                       input logic [15:0] ad, input logic br, input logic bl, input logic bw,
                       input logic [4:0] ba, input logic [15:0] bd);
    a_req = ar; a_lock = al; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_lock = bl; b_we = bw; b_addr = ba; b_wdata = bd;
  endtask

  // Drive at the falling edge, sample 1 time unit later
  task automatic step(input logic ar, input logic al, input logic aw, input logic [4:0] aa,
                      input logic [15:0] ad, input logic br, input logic bl, input logic bw,
                      input logic [4:0] ba, input logic [15:0] bd);
    @(negedge clk);
    drive(ar, al, aw, aa, ad, br, bl, bw, ba, bd);
    #1;
  endtask

  int agn;
  int bcyc;

  initial begin
    // Tie-break, read return, alternation, write-then-read across ports
    vecs[0]  = mk(1,0, 3,16'h0,    1,0, 3,16'h0,    1,0,0, 3, 0,16'h0,    0,16'h0);
    vecs[1]  = mk(0,0, 3,16'h0,    1,0, 3,16'h0,    0,1,0, 3, 1,16'h1234, 0,16'h0);
    vecs[2]  = mk(1,1,10,16'hAAAA, 1,0,11,16'h0,    1,0,1,10, 0,16'h1234, 1,16'h1234);
    vecs[3]  = mk(1,1,10,16'hAAAA, 1,0,11,16'h0,    0,1,0,11, 0,16'h1234, 0,16'h1234);
    vecs[4]  = mk(1,1,10,16'hAAAA, 1,0,11,16'h0,    1,0,1,10, 0,16'h1234, 1,16'h100B);
    vecs[5]  = mk(1,0,10,16'h0,    1,1,11,16'h5555, 0,1,1,11, 0,16'h1234, 0,16'h100B);
    vecs[6]  = mk(1,0,10,16'h0,    1,1,11,16'h5555, 1,0,0,10, 0,16'h1234, 0,16'h100B);
    vecs[7]  = mk(1,1, 7,16'hBEEF, 0,0, 0,16'h0,    1,0,1, 7, 1,16'hAAAA, 0,16'h100B);
    vecs[8]  = mk(0,0, 0,16'h0,    1,0, 7,16'h0,    0,1,0, 7, 0,16'hAAAA, 0,16'h100B);
    vecs[9]  = mk(0,0, 0,16'h0,    0,0, 0,16'h0,    0,0,0, 0, 0,16'hAAAA, 1,16'hBEEF);
    vecs[10] = mk(1,0,11,16'h0,    0,0, 0,16'h0,    1,0,0,11, 0,16'hAAAA, 0,16'hBEEF);
    vecs[11] = mk(0,0, 0,16'h0,    0,0, 0,16'h0,    0,0,0, 0, 1,16'h5555, 0,16'hBEEF);
    vecs[12] = mk(0,0, 0,16'h0,    0,0, 0,16'h0,    0,0,0, 0, 0,16'h5555, 0,16'hBEEF);

    // Reset with both requests asserted: no grants, no write strobe
    rst = 1'b1;
    drive(1, 0, 1, 5'd1, 16'h1, 1, 0, 1, 5'd2, 16'h2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_b_gnt", b_gnt, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_rvalid", {a_rvalid, b_rvalid}, 0);
    chk("rst_rdata", {a_rdata, b_rdata}, 0);
    drive(0, 0, 0, 5'd0, 16'h0, 0, 0, 0, 5'd0, 16'h0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].ar, 1'b0, vecs[i].aw, vecs[i].aa, vecs[i].ad,
           vecs[i].br, 1'b0, vecs[i].bw, vecs[i].ba, vecs[i].bd);
      chk($sformatf("v%0d_a_gnt", i), a_gnt, vecs[i].eag);
      chk($sformatf("v%0d_b_gnt", i), b_gnt, vecs[i].ebg);
      chk($sformatf("v%0d_mem_wen", i), mem_wen, vecs[i].ewen);
      chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].eaddr);
      chk($sformatf("v%0d_a_rvalid", i), a_rvalid, vecs[i].eav);
      chk($sformatf("v%0d_a_rdata", i), a_rdata, vecs[i].ead);
      chk($sformatf("v%0d_b_rvalid", i), b_rvalid, vecs[i].ebv);
      chk($sformatf("v%0d_b_rdata", i), b_rdata, vecs[i].ebd);
    end

    // A locked burst of 6 writes with B idle: unbounded lock, counter saturates
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 1, 5'(16 + i), 16'(16'hA0 + i), 0, 0, 0, 5'd0, 16'h0);
      chk($sformatf("burst%0d_a_gnt", i), a_gnt, 1);
      chk($sformatf("burst%0d_b_gnt", i), b_gnt, 0);
    end
    @(posedge clk);
    #1;
    chk("burst_cnt_sat", dut.cnt, 4);
    chk("burst_state", dut.state, ST_OWN_A);
    step(0, 0, 0, 5'd0, 16'h0, 0, 0, 0, 5'd0, 16'h0);
    chk("release_dead_a_gnt", a_gnt, 0);
    step(1, 0, 0, 5'd20, 16'h0, 0, 0, 0, 5'd0, 16'h0);
    chk("burst_rd_a_gnt", a_gnt, 1);
    chk("burst_rd_state", dut.state, ST_IDLE);
    step(0, 0, 0, 5'd0, 16'h0, 1, 0, 0, 5'd21, 16'h0);
    chk("burst_rd_a_rvalid", a_rvalid, 1);
    chk("burst_rd_a_rdata", a_rdata, 16'h00A4);
    chk("prep_b_gnt", b_gnt, 1);

    // A locked burst contended by B from A's first grant: exactly 4 A grants then B
    agn = 0;
    bcyc = -1;
    for (int c = 0; c < 10; c++) begin
      step(1, 1, 1, 5'd0, 16'h1111, 1, 0, 0, 5'd3, 16'h0);
      if (c == 0) chk("contend_b_rdata", b_rdata, 16'h00A5);
      if (a_gnt && b_gnt) chk("contend_one_grant", {a_gnt, b_gnt}, 2'b10);
      if (b_gnt) begin
        bcyc = c;
        break;
      end
      if (a_gnt) agn++;
    end
    chk("contend_a_count", agn, 4);
    chk("contend_b_cycle", bcyc, 4);
    step(1, 0, 0, 5'd3, 16'h0, 1, 0, 0, 5'd3, 16'h0);
    chk("after_release_a_wins", a_gnt, 1);

    // Reset pulse while B owns dcmem and a B read return is pending
    step(0, 0, 0, 5'd0, 16'h0, 1, 1, 0, 5'd3, 16'h0);
    chk("ownb_first_b_gnt", b_gnt, 1);
    step(0, 0, 0, 5'd0, 16'h0, 1, 1, 0, 5'd3, 16'h0);
    chk("ownb_second_b_gnt", b_gnt, 1);
    chk("ownb_state", dut.state, ST_OWN_B);
    @(posedge clk);
    #1;
    chk("pending_b_rvalid", b_rvalid, 1);
    drive(0, 0, 0, 5'd0, 16'h0, 0, 0, 0, 5'd0, 16'h0);
    rst = 1'b1;
    #1;
    chk("midrst_b_rvalid", b_rvalid, 0);
    chk("midrst_b_rdata", b_rdata, 0);
    chk("midrst_state", dut.state, ST_IDLE);
    rst = 1'b0;
    step(1, 0, 0, 5'd3, 16'h0, 1, 0, 0, 5'd3, 16'h0);
    chk("postrst_tie_a_gnt", a_gnt, 1);
    chk("postrst_tie_b_gnt", b_gnt, 0);
    step(0, 0, 0, 5'd0, 16'h0, 0, 0, 0, 5'd0, 16'h0);
    chk("postrst_a_rdata", a_rdata, 16'h1234);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
